// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist
// Purpose  : March C- built-in self-test controller for a synchronous
//            single-port SRAM with one cycle of read latency. It drives the
//            SRAM pins directly and checks every read word against the
//            expected background. It reports pass/fail, the first failing
//            address and word, and a saturating mismatch count.
// Ports    : clk, rst (synchronous, active-high)
//            start                      - one-cycle start request
//            mem_en/mem_we/mem_addr/
//            mem_wdata                  - SRAM control/address/write data
//            mem_rdata                  - SRAM registered read data
//            busy/done                  - test in progress / finished
//            fail/fail_addr/fail_data   - first-mismatch report (sticky)
//            err_count                  - mismatch count, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_bist #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // March elements are numbered 0..5 in execution order.
    localparam logic [2:0]        c_elem_last = 3'd5;
    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_elem;
    logic              r_phase;      // 0: first op at this address, 1: second op
    logic [ADDR_W-1:0] r_addr;

    logic              r_rd_pend;
    logic [DATA_W-1:0] r_rd_exp;
    logic [ADDR_W-1:0] r_rd_addr;

    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [7:0]        r_err_count;

    logic              w_run;
    logic              w_start_ok;
    logic              w_two_op;
    logic              w_down;
    logic              w_next_down;
    logic              w_is_write;
    logic              w_inv;
    logic [DATA_W-1:0] w_pattern;
    logic              w_addr_last;
    logic              w_op_last;
    logic              w_mismatch;

    // ------------------------------------------------------------------
    // Operation decode for the current (element, phase)
    //   M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)
    //   M3 dn(r0,w1)  M4 dn(r1,w0)  M5 up(r0)
    // ------------------------------------------------------------------
    assign w_run       = (r_state == S_RUN);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_two_op    = (r_elem != 3'd0) && (r_elem != c_elem_last);
    assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_next_down = (r_elem == 3'd2) || (r_elem == 3'd3);
    assign w_is_write  = (r_elem == 3'd0) || (w_two_op && r_phase);
    // M2/M4 read ones and write zeros; M1/M3 the opposite. M0/M5 use zeros.
    assign w_inv       = w_two_op && (r_phase ^ ((r_elem == 3'd2) || (r_elem == 3'd4)));
    assign w_pattern   = w_inv ? ~BG : BG;
    assign w_addr_last = w_down ? (r_addr == '0) : (&r_addr);
    assign w_op_last   = !w_two_op || r_phase;
    assign w_mismatch  = r_rd_pend && (mem_rdata != r_rd_exp);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_op_last && w_addr_last && (r_elem == c_elem_last)) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address/element sequencing, read pipeline and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_elem      <= '0;
            r_phase     <= 1'b0;
            r_addr      <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_exp    <= '0;
            r_rd_addr   <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_err_count <= '0;
        end else begin
            // A read issued this cycle is compared on the next one.
            r_rd_pend <= w_run && !w_is_write;
            r_rd_exp  <= w_pattern;
            r_rd_addr <= r_addr;

            if (w_start_ok) begin
                r_elem      <= '0;
                r_phase     <= 1'b0;
                r_addr      <= '0;
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_err_count <= '0;
            end else begin
                if (w_run) begin
                    if (!w_op_last) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (w_addr_last) begin
                            // Element boundary: reload the address for the
                            // direction of the next element.
                            if (r_elem == c_elem_last) begin
                                r_elem <= '0;
                                r_addr <= '0;
                            end else begin
                                r_elem <= r_elem + 3'd1;
                                r_addr <= w_next_down ? '1 : '0;
                            end
                        end else if (w_down) begin
                            r_addr <= r_addr - c_addr_one;
                        end else begin
                            r_addr <= r_addr + c_addr_one;
                        end
                    end
                end

                if (w_mismatch) begin
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    if (!r_fail) begin
                        r_fail      <= 1'b1;
                        r_fail_addr <= r_rd_addr;
                        r_fail_data <= mem_rdata;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_en    = w_run;
    assign mem_we    = w_run && w_is_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = (w_run && w_is_write) ? w_pattern : '0;
    assign busy      = (r_state == S_RUN) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test controller for the 256x8 synchronous SRAM. Sits directly upstream of the SRAM and drives its enable, we, addr and data_in pins.
- Runs a March C- sequence over every address and checks each registered read word on data_out.
- Reports pass/fail, the first failing address and word, and a saturating error count.
- Any functional/BIST mux outside this block is not part of it.

Parameters:
- ADDR_W, 8, memory address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, memory word width.
- BG, 8'h00, background pattern. "0" writes BG; "1" writes ~BG.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle start request.
- mem_en  out  1  to SRAM enable.
- mem_we  out  1  to SRAM we.
- mem_addr  out  ADDR_W  to SRAM addr.
- mem_wdata  out  DATA_W  to SRAM data_in.
- mem_rdata  in  DATA_W  from SRAM data_out; 1-cycle read latency.
- busy  out  1  test in progress.
- done  out  1  test finished; sticky until next start or rst.
- fail  out  1  at least one mismatch; sticky.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_data  out  DATA_W  word read at first mismatch.
- err_count  out  8  mismatch count, saturates at 255.

Behaviour:
- Reset: state IDLE. mem_en, mem_we, busy, done and fail = 0. mem_addr, mem_wdata, fail_addr, fail_data, err_count = 0. Read pipeline cleared.
- States: IDLE -> RUN -> CHECK -> DONE.
- IDLE/DONE: start=1 sampled -> RUN. On the same edge clear fail, fail_addr, fail_data, err_count and done; set busy=1.
- RUN: one memory op per cycle, mem_en=1 every RUN cycle, no idle cycles. March elements in order:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Address order: up = 0..DEPTH-1; down = DEPTH-1..0.
- Within an element, all ops for one address are issued before moving to the next address.
- Read op: mem_we=0. Write op: mem_we=1, mem_wdata = BG or ~BG. mem_wdata = 0 on read cycles.
- Op cycles with DEPTH=256: M0 256, M1–M4 512 each, M5 256; total 2560.
- Read check: a read issued in cycle t registers {pending, expected, addr}. In cycle t+1, mem_rdata is compared with expected and the result is acted on at the end of t+1.
  - The write issued in cycle t+1 does not disturb mem_rdata, because the SRAM holds data_out on write cycles.
- Mismatch:
  - err_count += 1, saturating at 255.
  - If fail=0: set fail=1, capture fail_addr and fail_data=mem_rdata.
  - Later mismatches only increment err_count.
- After the last M5 read: -> CHECK for 1 cycle. mem_en=0; the final read is compared.
- CHECK -> DONE. DONE outputs: busy=0, done=1; fail, fail_addr, fail_data and err_count hold.
- Timing: start sampled at edge N -> first op in the cycle after edge N; CHECK entered at edge N+2560; done=1 after edge N+2561.
- start while RUN/CHECK: ignored.
- start held high: restarts only from IDLE/DONE.
- rst during RUN: next edge -> IDLE with reset values, mem_en=0 immediately after that edge. SRAM contents are not restored.
- mem_en=0 in IDLE, CHECK and DONE.
- Address counter wraps only at element boundaries; no out-of-range address is ever driven.

Test Plan:
- Fault-free 256x8 model, BG=8'h00, start pulse at edge N:
  - mem_en high for exactly 2560 consecutive cycles.
  - First op is w 0x00 @0x00; last op is r @0xFF.
  - done=1 after edge N+2561, busy=0, fail=0, err_count=0.
- Model bit0 stuck-at-1 @0x3C:
  - r0 fails in M1, M3 and M5 -> err_count=3.
  - fail=1, fail_addr=0x3C, fail_data=0x01.
- Model bit7 stuck-at-0 @0xFF:
  - r1 fails in M2 and M4 -> err_count=2.
  - fail_addr=0xFF, fail_data=0x7F.
- Op-sequence check, fault-free:
  - Cycles 256–257: r@0x00 then w 0xFF @0x00.
  - First M3 ops (cycles 1280–1281): r@0xFF then w@0xFF.
  - No mismatch flagged on any write cycle.
- rst at cycle 700 of RUN:
  - Next cycle: mem_en=0, busy=0, done=0, err_count=0.
  - A new start completes a clean run with done after 2561 cycles.
- start pulsed at cycle 100 of RUN: no effect, done timing unchanged. A start pulse in DONE after a failing run clears fail and err_count and reruns.
